// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the 16-bit XNOR PRBS generator/checker pair.
// Revision: 1.0
`default_nettype none

package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'h0145;

  localparam int TAP_A = 15;
  localparam int TAP_B = 14;
  localparam int TAP_C = 12;
  localparam int TAP_D = 3;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // XNOR form: the all-ones word is the lockup state, all-zeros is legal.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_err_window.sv
// lfsr_err_window: per-window error accounting while locked; flags loss of lock.
// Revision: 1.0
`default_nettype none

module lfsr_err_window #(
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic bit_err,
  output logic loss_of_lock
);

  localparam int BW = $clog2(WINDOW + 1);

  logic [BW-1:0] win_bits;
  logic [BW-1:0] win_err;
  logic [BW-1:0] err_next;
  logic          window_end;

  // win_err never rests at ERR_THRESH, so hitting it implies this bit erred.
  always_comb begin
    err_next     = win_err + BW'(bit_err);
    window_end   = (win_bits == BW'(WINDOW - 1));
    loss_of_lock = en && (err_next == BW'(ERR_THRESH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_bits <= '0;
      win_err  <= '0;
    end else if (en) begin
      if (loss_of_lock || window_end) begin
        win_bits <= '0;
        win_err  <= '0;
      end else begin
        win_bits <= win_bits + BW'(1);
        win_err  <= err_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising PRBS receiver with flywheel, error count and seed tick.
// Revision: 1.0
`default_nettype none

module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED,
  parameter int                LOCK_CNT   = 32,
  parameter int                WINDOW     = 64,
  parameter int                ERR_THRESH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sh_en,
  input  logic        rx_bit,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic        seed_tick
);

  localparam int FILL_W = $clog2(LFSR_W + 1);

  chk_state_t        state;
  chk_state_t        state_next;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_next;
  logic [FILL_W-1:0] fill_cnt;
  logic [FILL_W-1:0] fill_next;
  logic [7:0]        match_cnt;
  logic [7:0]        match_next;
  logic [15:0]       cnt_base;
  logic [15:0]       cnt_next;
  logic              pred;
  logic              mismatch;
  logic              win_en;
  logic              loss_of_lock;

  // Once locked the register flywheels on its own prediction.
  always_comb begin
    pred      = lfsr_fb(lfsr_q);
    mismatch  = rx_bit ^ pred;
    lfsr_next = {lfsr_q[LFSR_W-2:0], (state == LOCKED) ? pred : rx_bit};
    win_en    = sh_en && (state == LOCKED);
    cnt_base  = clr_cnt ? 16'h0000 : err_cnt;
    cnt_next  = (win_en && mismatch && (cnt_base != 16'hFFFF)) ? cnt_base + 16'd1 : cnt_base;
  end

  lfsr_err_window #(
    .WINDOW     (WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_err_window (
    .clk          (clk),
    .reset        (reset),
    .en           (win_en),
    .bit_err      (mismatch),
    .loss_of_lock (loss_of_lock)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    fill_next  = fill_cnt;
    match_next = match_cnt;
    case (state)
      HUNT: begin
        if (sh_en) begin
          if (lfsr_q == '1) begin
            fill_next  = '0;
            match_next = '0;
          end else if (fill_cnt != FILL_W'(LFSR_W)) begin
            fill_next = fill_cnt + FILL_W'(1);
          end else if (mismatch) begin
            match_next = '0;
          end else if (match_cnt == 8'(LOCK_CNT - 1)) begin
            state_next = LOCKED;
            match_next = '0;
          end else begin
            match_next = match_cnt + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (loss_of_lock) begin
          state_next = HUNT;
          fill_next  = '0;
          match_next = '0;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q    <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      err       <= 1'b0;
      err_cnt   <= 16'h0000;
      seed_tick <= 1'b0;
    end else begin
      fill_cnt  <= fill_next;
      match_cnt <= match_next;
      if (sh_en) lfsr_q <= lfsr_next;
      err       <= win_en && mismatch;
      seed_tick <= win_en && (lfsr_next == SEED);
      err_cnt   <= cnt_next;
    end
  end

  assign locked = (state == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: golden generator plus behavioural receiver model driving lfsr_checker.
// Revision: 1.0
`default_nettype none

module tb_lfsr_checker;

  localparam logic [15:0] SEED       = 16'h0145;
  localparam int          LOCK_CNT   = 32;
  localparam int          WINDOW     = 64;
  localparam int          ERR_THRESH = 8;
  localparam int          ACQ        = 16 + LOCK_CNT;
  localparam int          PERIOD     = 65535;
  localparam int          PRE        = 150;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sh_en = 1'b0;
  logic        rx_bit = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic        seed_tick;

  lfsr_checker #(
    .SEED       (SEED),
    .LOCK_CNT   (LOCK_CNT),
    .WINDOW     (WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sh_en     (sh_en),
    .rx_bit    (rx_bit),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .seed_tick (seed_tick)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] gen;
  logic [15:0] hist;
  bit          m_locked;
  bit          m_err;
  bit          m_tick;
  int          m_hunt;
  int          m_wbits;
  int          m_werr;
  int          m_cnt;
  int          vbit;
  int          tick_at[$];

  function automatic logic [15:0] gen_step(input logic [15:0] s);
    return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_tick   = 1'b0;
    m_hunt   = 0;
    m_wbits  = 0;
    m_werr   = 0;
    m_cnt    = 0;
    hist     = 16'h0000;
    vbit     = 0;
  endtask

  // One clock: drive inputs, advance the reference, then compare after the edge.
  task automatic step(input bit en, input bit flip, input bit clr);
    bit          clean;
    bit          e;
    logic [15:0] hn;
    clean   = gen[15];
    sh_en   = en;
    clr_cnt = clr;
    rx_bit  = en ? (clean ^ flip) : 1'($urandom);
    if (clr) m_cnt = 0;
    if (en) begin
      e      = m_locked && flip;
      hn     = {hist[14:0], clean};
      m_err  = e;
      m_tick = m_locked && (hn == SEED);
      if (e && m_cnt < 65535) m_cnt++;
      if (m_locked) begin
        m_wbits++;
        m_werr += int'(e);
        if (m_werr == ERR_THRESH) begin
          m_locked = 1'b0;
          m_hunt   = 0;
          m_wbits  = 0;
          m_werr   = 0;
        end else if (m_wbits == WINDOW) begin
          m_wbits = 0;
          m_werr  = 0;
        end
      end else begin
        m_hunt++;
        if (m_hunt == ACQ) begin
          m_locked = 1'b1;
          m_wbits  = 0;
          m_werr   = 0;
        end
      end
      hist = hn;
      gen  = gen_step(gen);
      vbit++;
    end else begin
      m_err  = 1'b0;
      m_tick = 1'b0;
    end
    @(posedge clk);
    #1;
    if (seed_tick === 1'b1) tick_at.push_back(vbit);
    check("locked", 32'(locked), 32'(m_locked));
    check("err", 32'(err), 32'(m_err));
    check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    check("seed_tick", 32'(seed_tick), 32'(m_tick));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_seed_tick"}, 32'(seed_tick), 32'd0);
  endtask

  initial begin
    int sp;
    model_reset();
    gen = SEED;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Constant ones: the register sits in the XNOR lockup word and must never lock.
    for (int i = 0; i < 200; i++) begin
      sh_en  = 1'b1;
      rx_bit = 1'b1;
      @(posedge clk);
      #1;
      check("lockup_locked", 32'(locked), 32'd0);
    end
    check("lockup_err_cnt", 32'(err_cnt), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Acquisition from the generator seed.
    model_reset();
    gen = SEED;
    for (int i = 0; i < ACQ - 1; i++) step(1'b1, 1'b0, 1'b0);
    check("acq_before", 32'(locked), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("acq_bit48", 32'(locked), 32'd1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);

    // Single flip, then the flywheel must hold.
    step(1'b1, 1'b1, 1'b0);
    check("flip_err", 32'(err), 32'd1);
    check("flip_cnt", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
    check("flip_hold_cnt", 32'(err_cnt), 32'd1);
    check("flip_hold_locked", 32'(locked), 32'd1);

    step(1'b1, 1'b0, 1'b1);
    check("clr_alone", 32'(err_cnt), 32'd0);

    // Burst of ERR_THRESH flips inside one fresh window.
    for (int i = 0; i < WINDOW && m_wbits != 0; i++) step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < ERR_THRESH; k++) begin
      repeat ($urandom_range(0, 6)) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    check("burst_locked", 32'(locked), 32'd0);
    check("burst_cnt", 32'(err_cnt), 32'(ERR_THRESH));
    for (int i = 0; i < ACQ - 1; i++) step(1'b1, 1'b0, 1'b0);
    check("relock_before", 32'(locked), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("relock_at48", 32'(locked), 32'd1);

    step(1'b1, 1'b1, 1'b1);
    check("clr_with_err", 32'(err_cnt), 32'd1);

    // Random stalls with sparse errors; the model tracks any resulting loss of lock.
    for (int i = 0; i < 400; i++)
      step(($urandom % 2) == 0, m_locked && (($urandom % 40) == 0), ($urandom % 64) == 0);

    for (int i = 0; i < 2 * ACQ && !m_locked; i++) step(1'b1, 1'b0, 1'b0);
    check("pre_reset_locked", 32'(locked), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    check_all_zero("held_reset");

    // Period: start the generator PRE bits ahead of its return to SEED.
    model_reset();
    gen = SEED;
    for (int i = 0; i < PERIOD - PRE; i++) gen = gen_step(gen);
    tick_at.delete();
    reset = 1'b1;
    for (int cyc = 0; cyc < 120000 && vbit < PRE + 16 + PERIOD + 50; cyc++)
      step(($urandom % 8) != 0, 1'b0, 1'b0);
    check("period_reached", 32'(vbit >= PRE + 16 + PERIOD + 50), 32'd1);
    check("tick_count", 32'(tick_at.size()), 32'd2);
    sp = (tick_at.size() >= 2) ? tick_at[1] - tick_at[0] : 0;
    check("tick_first", 32'((tick_at.size() >= 1) ? tick_at[0] : 0), 32'(PRE + 16));
    check("tick_spacing", 32'(sp), 32'(PERIOD));
    check("period_err_cnt", 32'(err_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
